// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port, registered-output frame-buffer RAM between the VGA
// pixel-fetch path and a pixel writer. Display reads always win and are never
// stalled. Writes are parked in a small circular queue and retired, in accept
// order, on any cycle without a display read. A sticky status flag reports a
// queue that was held off by reads for STARVE_LIM consecutive cycles. This
// usually means the display timing leaves no blanking gaps for the writer.
//
// Parameters
//   ADDR_W      frame-buffer address width
//   DATA_W      pixel width
//   WQ_DEPTH    write-queue entries (power of 2, >= 2)
//   STARVE_LIM  consecutive blocked cycles that raise starve_err
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   rd_req      display read request, one address per cycle
//   rd_addr     display read address
//   rd_valid    rd_data valid (two cycles after rd_req)
//   rd_data     display read data, holds its last value when rd_valid is low
//   wr_valid    writer presents a write
//   wr_ready    queue has room; transfer on wr_valid & wr_ready
//   wr_addr     write address
//   wr_data     write pixel
//   ram_en      RAM access this cycle
//   ram_we      1 = write, 0 = read
//   ram_addr    RAM address
//   ram_wdata   RAM write data
//   ram_rdata   RAM read data, valid the cycle after a read
//   wq_level    write-queue occupancy
//   starve_err  sticky write-queue starvation flag
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 3,
  parameter int WQ_DEPTH   = 4,
  parameter int STARVE_LIM = 1024,
  localparam int PTR_W     = $clog2(WQ_DEPTH),
  localparam int LVL_W     = PTR_W + 1,
  localparam int CNT_W     = $clog2(STARVE_LIM + 1)
) (
  input  logic              clk,
  input  logic              reset,
  // display read port
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  // pixel writer port
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  // frame-buffer RAM port
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  // status
  output logic [LVL_W-1:0]  wq_level,
  output logic              starve_err
);

  // Who owns the RAM in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

  // ---------------------------------------------------------------------------
  // Write queue state
  // ---------------------------------------------------------------------------
  wq_entry_t        wq_mem [WQ_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [LVL_W-1:0] level;
  wq_entry_t        head_entry;

  grant_t           grant;
  logic             push;
  logic             pop;

  // Read pipeline: rd_pend marks that ram_rdata carries a display read.
  logic             rd_pend;

  // Starvation tracking
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  assign head_entry = wq_mem[head];

  // wr_ready depends only on registered occupancy, so a pop in this cycle
  // never opens a slot for a push in the same cycle.
  assign wr_ready = (level < LVL_W'(WQ_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (grant == GNT_WRITE);
  assign wq_level = level;

  // ---------------------------------------------------------------------------
  // Arbitration and RAM drive (purely combinational)
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant     = GNT_NONE;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    if (rd_req) begin
      grant = GNT_READ;
    end else if (level != '0) begin
      grant = GNT_WRITE;
    end

    unique case (grant)
      GNT_READ: begin
        ram_en   = 1'b1;
        ram_addr = rd_addr;
      end
      GNT_WRITE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = head_entry.addr;
        ram_wdata = head_entry.data;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      // Pointers wrap naturally because WQ_DEPTH is a power of two.
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: queue storage has no reset; an entry is only ever read after it was
  // written, and the pointers are what make the queue empty after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      wq_mem[tail] <= '{addr: wr_addr, data: wr_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Display read pipeline: request at N, RAM data at N+1, rd_data at N+2
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= rd_req;
      rd_valid <= rd_pend;
      if (rd_pend) begin
        rd_data <= ram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation monitor
  // ---------------------------------------------------------------------------
  // Counts cycles where the queue holds data but a display read blocks it.
  // Any pop or an empty queue restarts the count; it saturates at the limit.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if ((level == '0) || pop) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIM)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      starve_err <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      // Flag rises on the edge where the count reaches the limit, then sticks.
      if (starve_cnt_nxt == CNT_W'(STARVE_LIM)) begin
        starve_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Directed bench for vga_fb_arbiter. A behavioural registered RAM is attached
// to the RAM port; its initial content at every address is addr[2:0], so the
// expected read data can be worked out by hand. Inputs change 1 ns after the
// rising edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 3;
  localparam int WQ_DEPTH   = 4;
  localparam int STARVE_LIM = 1024;
  localparam int LVL_W      = $clog2(WQ_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [LVL_W-1:0]  wq_level;
  logic              starve_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .WQ_DEPTH  (WQ_DEPTH),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .wq_level  (wq_level),
    .starve_err(starve_err)
  );

  // Behavioural frame-buffer RAM with a registered read port.
  logic [DATA_W-1:0] fb_mem [0:(1<<ADDR_W)-1];
  int                ram_writes = 0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) fb_mem[i] <= DATA_W'(i);
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        fb_mem[ram_addr] <= ram_wdata;
        ram_writes       <= ram_writes + 1;
      end else begin
        ram_rdata <= fb_mem[ram_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset    = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
    end
    checks++;
    if (wq_level !== LVL_W'(0)) begin
      errors++; $display("FAIL reset_level: got %0d expected 0", wq_level);
    end
    checks++;
    if (ram_en !== 1'b0) begin
      errors++; $display("FAIL reset_ram_en: got %b expected 0", ram_en);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 3'b000) begin
      errors++; $display("FAIL reset_rd: got valid=%b data=%b expected 0/000", rd_valid, rd_data);
    end
    checks++;
    if (starve_err !== 1'b0) begin
      errors++; $display("FAIL reset_starve: got %b expected 0", starve_err);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_read();
    // Single read of 0x0005 (content 3'b101), latency 2.
    step();
    rd_req  = 1'b1;
    rd_addr = 14'h0005;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 14'h0005) begin
      errors++;
      $display("FAIL read_drive: got en=%b we=%b addr=%h expected 1/0/0005", ram_en, ram_we, ram_addr);
    end
    step();
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL read_n1_valid: got %b expected 0", rd_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 3'b101) begin
      errors++; $display("FAIL read_n2: got valid=%b data=%b expected 1/101", rd_valid, rd_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 3'b101) begin
      errors++; $display("FAIL read_hold: got valid=%b data=%b expected 0/101", rd_valid, rd_data);
    end

    // Three back-to-back reads of 0x000A..0x000C (contents 2,3,4).
    for (int c = 0; c < 6; c++) begin
      logic [DATA_W-1:0] exp_d;
      step();
      rd_req  = (c < 3);
      rd_addr = ADDR_W'(10 + c);
      @(negedge clk);
      checks++;
      if (c >= 2 && c < 5) begin
        exp_d = DATA_W'(c);
        if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
          errors++;
          $display("FAIL read_b2b c=%0d: got valid=%b data=%0d expected 1/%0d", c, rd_valid, rd_data, exp_d);
        end
      end else if (rd_valid !== 1'b0) begin
        errors++; $display("FAIL read_b2b c=%0d: got valid=%b expected 0", c, rd_valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_writes();
    // Four writes with no reads; each retires the cycle after it is accepted.
    for (int c = 0; c < 6; c++) begin
      step();
      rd_req   = 1'b0;
      wr_valid = (c < 4);
      wr_addr  = ADDR_W'(14'h100 + c);
      wr_data  = DATA_W'(c + 1);
      @(negedge clk);
      checks++;
      if (c == 0 || c == 5) begin
        if (ram_en !== 1'b0 || wq_level !== LVL_W'(0) || wr_ready !== 1'b1) begin
          errors++;
          $display("FAIL wr_idle c=%0d: got en=%b level=%0d ready=%b expected 0/0/1", c, ram_en, wq_level, wr_ready);
        end
      end else begin
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== ADDR_W'(14'h100 + c - 1) ||
            ram_wdata !== DATA_W'(c) || wq_level !== LVL_W'(1) || wr_ready !== 1'b1) begin
          errors++;
          $display("FAIL wr_retire c=%0d: got en=%b we=%b addr=%h data=%0d level=%0d ready=%b expected 1/1/%h/%0d/1/1",
                   c, ram_en, ram_we, ram_addr, ram_wdata, wq_level, wr_ready, 14'h100 + c - 1, c);
        end
      end
    end
    wr_valid = 1'b0;

    // Read 0x102 back through the arbiter: it was written with 3.
    step();
    rd_req  = 1'b1;
    rd_addr = 14'h0102;
    step();
    rd_req  = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 3'd3) begin
      errors++; $display("FAIL wr_readback: got valid=%b data=%0d expected 1/3", rd_valid, rd_data);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    // Reads block the queue until it fills; then four writes drain in a row
    // and the fifth, held by the writer, is accepted once a slot opens.
    int exp_lvl [11] = '{0, 1, 2, 3, 4, 4, 3, 3, 2, 1, 0};
    for (int c = 0; c < 11; c++) begin
      int idx;
      idx      = (c < 4) ? c : 4;
      step();
      rd_req   = (c < 5);
      rd_addr  = 14'h0300;
      wr_valid = (c < 7);
      wr_addr  = ADDR_W'(14'h200 + idx);
      wr_data  = DATA_W'(7 - idx);
      @(negedge clk);
      checks++;
      if (wq_level !== LVL_W'(exp_lvl[c]) || wr_ready !== (exp_lvl[c] < WQ_DEPTH)) begin
        errors++;
        $display("FAIL b2b_level c=%0d: got level=%0d ready=%b expected %0d/%b",
                 c, wq_level, wr_ready, exp_lvl[c], exp_lvl[c] < WQ_DEPTH);
      end
      checks++;
      if (c < 5) begin
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 14'h0300) begin
          errors++;
          $display("FAIL b2b_read c=%0d: got en=%b we=%b addr=%h expected 1/0/0300", c, ram_en, ram_we, ram_addr);
        end
      end else if (c < 10) begin
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== ADDR_W'(14'h200 + c - 5) ||
            ram_wdata !== DATA_W'(7 - (c - 5))) begin
          errors++;
          $display("FAIL b2b_write c=%0d: got en=%b we=%b addr=%h data=%0d expected 1/1/%h/%0d",
                   c, ram_en, ram_we, ram_addr, ram_wdata, 14'h200 + c - 5, 7 - (c - 5));
        end
      end else if (ram_en !== 1'b0) begin
        errors++; $display("FAIL b2b_idle: got en=%b expected 0", ram_en);
      end
    end
    wr_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starve();
    // One queued write blocked by continuous reads.
    step();
    rd_req   = 1'b1;
    rd_addr  = 14'h0000;
    wr_valid = 1'b1;
    wr_addr  = 14'h0400;
    wr_data  = 3'd6;
    @(negedge clk);
    checks++;
    if (starve_err !== 1'b0) begin
      errors++; $display("FAIL starve_pre: got %b expected 0", starve_err);
    end
    step();
    wr_valid = 1'b0;
    repeat (STARVE_LIM - 1) step();
    // 1023 blocked cycles completed; the 1024th is in progress.
    @(negedge clk);
    checks++;
    if (starve_err !== 1'b0 || wq_level !== LVL_W'(1)) begin
      errors++; $display("FAIL starve_early: got err=%b level=%0d expected 0/1", starve_err, wq_level);
    end
    step();
    @(negedge clk);
    checks++;
    if (starve_err !== 1'b1) begin
      errors++; $display("FAIL starve_set: got %b expected 1", starve_err);
    end
    step();
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0400) begin
      errors++; $display("FAIL starve_drain: got we=%b addr=%h expected 1/0400", ram_we, ram_addr);
    end
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (starve_err !== 1'b1 || wq_level !== LVL_W'(0)) begin
      errors++; $display("FAIL starve_sticky: got err=%b level=%0d expected 1/0", starve_err, wq_level);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int writes_before;
    for (int c = 0; c < 3; c++) begin
      step();
      rd_req   = 1'b1;
      rd_addr  = 14'h0005;
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(14'h380 + c);
      wr_data  = DATA_W'(c + 1);
    end
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wq_level !== LVL_W'(3)) begin
      errors++; $display("FAIL mid_level_pre: got %0d expected 3", wq_level);
    end
    writes_before = ram_writes;
    #2;
    reset  = 1'b1;
    rd_req = 1'b0;
    #1;
    checks++;
    if (wq_level !== LVL_W'(0) || wr_ready !== 1'b1 || rd_valid !== 1'b0 ||
        rd_data !== 3'b000 || starve_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got level=%0d ready=%b valid=%b data=%b err=%b expected 0/1/0/000/0",
               wq_level, wr_ready, rd_valid, rd_data, starve_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || ram_en !== 1'b0 || wq_level !== LVL_W'(0)) begin
        errors++;
        $display("FAIL mid_after c=%0d: got valid=%b en=%b level=%0d expected 0/0/0", c, rd_valid, ram_en, wq_level);
      end
    end
    checks++;
    if (ram_writes !== writes_before) begin
      errors++; $display("FAIL mid_no_write: got %0d writes expected %0d", ram_writes, writes_before);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_read();
    test_writes();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
